// File: rtl/mux8_scan_ctrl.sv
// Scan sequencer for an 8:1 data-select mux: steps the select lines over the
// enabled channels, samples Y after a settle delay and hands out 8-bit frames.
module mux8_scan_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       continuous,
    input  logic [7:0] ch_mask,
    output logic [2:0] ds,
    output logic       g_n,
    input  logic       y_in,
    output logic [7:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t     state_q;
    logic [2:0] ds_q;
    logic       gn_q;
    logic [7:0] frame_q;
    logic       frameValid_q;
    logic       busy_q;
    logic       overrun_q;
    logic [7:0] mask_q;
    logic [7:0] acc_q;
    logic [3:0] cnt_q;

    logic [2:0] armFirst_d;
    logic       armAny_d;
    logic [2:0] nextIdx_d;
    logic       nextFound_d;
    logic       armNow_d;
    logic       slotFree_d;

    // Lowest enabled channel of the incoming mask, and the next enabled
    // channel above the current select within the latched mask.
    always_comb begin
        armFirst_d  = 3'd0;
        armAny_d    = |ch_mask;
        nextIdx_d   = 3'd0;
        nextFound_d = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (ch_mask[i]) begin
                armFirst_d = 3'(i);
            end
            if (mask_q[i] && (3'(i) > ds_q)) begin
                nextIdx_d   = 3'(i);
                nextFound_d = 1'b1;
            end
        end
        armNow_d   = ((state_q == S_IDLE) && start) ||
                     ((state_q == S_DONE) && continuous);
        slotFree_d = !frameValid_q || frame_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ds_q         <= 3'd0;
            gn_q         <= 1'b1;
            frame_q      <= 8'd0;
            frameValid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            mask_q       <= 8'd0;
            acc_q        <= 8'd0;
            cnt_q        <= 4'd0;
        end else begin
            if (frameValid_q && frame_ready) begin
                frameValid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    gn_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
                S_SETTLE: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    acc_q[ds_q] <= y_in;
                    if (nextFound_d) begin
                        ds_q    <= nextIdx_d;
                        cnt_q   <= 4'(SETTLE - 1);
                        state_q <= S_SETTLE;
                    end else begin
                        gn_q    <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    // A full slot keeps the pending frame; the new one is dropped.
                    if (slotFree_d) begin
                        frame_q      <= acc_q;
                        frameValid_q <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            // Arming from IDLE or re-arming from DONE overrides the above.
            if (armNow_d) begin
                mask_q <= ch_mask;
                acc_q  <= 8'd0;
                busy_q <= 1'b1;
                if (armAny_d) begin
                    ds_q    <= armFirst_d;
                    gn_q    <= 1'b0;
                    cnt_q   <= 4'(SETTLE - 1);
                    state_q <= S_SETTLE;
                end else begin
                    state_q <= S_DONE;
                end
            end
        end
    end

    assign ds          = ds_q;
    assign g_n         = gn_q;
    assign frame       = frame_q;
    assign frame_valid = frameValid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Directed bench for mux8_scan_ctrl driving Y from a behavioural 74LS151 model.
module tb_mux8_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       continuous;
    logic [7:0] ch_mask;
    logic [2:0] ds;
    logic       g_n;
    logic       y_in;
    logic [7:0] frame;
    logic       frame_valid;
    logic       frame_ready;
    logic       busy;
    logic       overrun;
    logic [7:0] dIn;

    int checks = 0;
    int errors = 0;

    mux8_scan_ctrl #(.SETTLE(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .ch_mask    (ch_mask),
        .ds         (ds),
        .g_n        (g_n),
        .y_in       (y_in),
        .frame      (frame),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // 74LS151: Y is forced low while the strobe is high.
    assign y_in = g_n ? 1'b0 : dIn[ds];

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; continuous = 1'b0; ch_mask = 8'h00;
        frame_ready = 1'b0; dIn = 8'h00;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_ds", 8'(ds), 8'h0);
        checkOutput("rst_gn", 8'(g_n), 8'h1);
        checkOutput("rst_frame", frame, 8'h00);
        checkOutput("rst_fv", 8'(frame_valid), 8'h0);
        checkOutput("rst_busy", 8'(busy), 8'h0);
        checkOutput("rst_ovr", 8'(overrun), 8'h0);
        rst = 1'b0;
        applyStimulus();

        // Full mask, every channel visited in order
        $display("[TB] full mask scan");
        dIn = 8'hA5; ch_mask = 8'hFF; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            checkOutput($sformatf("t1_gn_c%0d", c), 8'(g_n), (c <= 24) ? 8'h0 : 8'h1);
            if (c <= 24) checkOutput($sformatf("t1_ds_c%0d", c), 8'(ds), 8'((c - 1) / 3));
            checkOutput($sformatf("t1_fv_c%0d", c), 8'(frame_valid), (c >= 26) ? 8'h1 : 8'h0);
            if (c < 26) applyStimulus();
        end
        checkOutput("t1_frame", frame, 8'hA5);
        checkOutput("t1_busy", 8'(busy), 8'h0);
        frame_ready = 1'b1;
        applyStimulus();
        frame_ready = 1'b0;
        checkOutput("t1_fv_drop", 8'(frame_valid), 8'h0);

        // Sparse mask: only channels 2 and 5
        $display("[TB] sparse mask scan");
        dIn = 8'hFF; ch_mask = 8'h24; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checkOutput($sformatf("t2_gn_c%0d", c), 8'(g_n), (c <= 6) ? 8'h0 : 8'h1);
            if (c <= 6) checkOutput($sformatf("t2_ds_c%0d", c), 8'(ds), (c <= 3) ? 8'h2 : 8'h5);
            checkOutput($sformatf("t2_fv_c%0d", c), 8'(frame_valid), (c == 8) ? 8'h1 : 8'h0);
            if (c < 8) applyStimulus();
        end
        checkOutput("t2_frame", frame, 8'h24);
        frame_ready = 1'b1;
        applyStimulus();
        frame_ready = 1'b0;

        // Empty mask goes straight to DONE
        $display("[TB] empty mask");
        ch_mask = 8'h00; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        checkOutput("t3_gn_c1", 8'(g_n), 8'h1);
        checkOutput("t3_busy_c1", 8'(busy), 8'h1);
        checkOutput("t3_fv_c1", 8'(frame_valid), 8'h0);
        applyStimulus();
        checkOutput("t3_gn_c2", 8'(g_n), 8'h1);
        checkOutput("t3_fv_c2", 8'(frame_valid), 8'h1);
        checkOutput("t3_frame", frame, 8'h00);
        checkOutput("t3_busy_c2", 8'(busy), 8'h0);
        frame_ready = 1'b1;
        applyStimulus();
        frame_ready = 1'b0;

        // Continuous mode with a stalled consumer
        $display("[TB] continuous with backpressure");
        dIn = 8'h01; ch_mask = 8'h01; continuous = 1'b1; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        applyStimulus(); applyStimulus(); applyStimulus();
        checkOutput("t4_fv_c4", 8'(frame_valid), 8'h0);
        applyStimulus();
        checkOutput("t4_fv_c5", 8'(frame_valid), 8'h1);
        checkOutput("t4_frame_c5", frame, 8'h01);
        checkOutput("t4_busy_c5", 8'(busy), 8'h1);
        dIn = 8'h00;
        applyStimulus(); applyStimulus(); applyStimulus();
        checkOutput("t4_ovr_c8", 8'(overrun), 8'h0);
        applyStimulus();
        checkOutput("t4_ovr_c9", 8'(overrun), 8'h1);
        checkOutput("t4_frame_c9", frame, 8'h01);
        checkOutput("t4_fv_c9", 8'(frame_valid), 8'h1);
        continuous = 1'b0; frame_ready = 1'b1;
        applyStimulus();
        frame_ready = 1'b0;
        checkOutput("t4_fv_c10", 8'(frame_valid), 8'h0);
        applyStimulus(); applyStimulus(); applyStimulus();
        checkOutput("t4_fv_c13", 8'(frame_valid), 8'h1);
        checkOutput("t4_frame_c13", frame, 8'h00);
        checkOutput("t4_busy_c13", 8'(busy), 8'h0);
        checkOutput("t4_ovr_c13", 8'(overrun), 8'h1);

        // Reset in the middle of channel 3 settle, then a clean rescan
        $display("[TB] reset mid-scan");
        dIn = 8'hA5; ch_mask = 8'hFF; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        for (int c = 1; c < 10; c++) applyStimulus();
        checkOutput("t5_ds_c10", 8'(ds), 8'h3);
        checkOutput("t5_gn_c10", 8'(g_n), 8'h0);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkOutput("t5_ds_rst", 8'(ds), 8'h0);
        checkOutput("t5_gn_rst", 8'(g_n), 8'h1);
        checkOutput("t5_busy_rst", 8'(busy), 8'h0);
        checkOutput("t5_fv_rst", 8'(frame_valid), 8'h0);
        checkOutput("t5_ovr_rst", 8'(overrun), 8'h0);
        ch_mask = 8'h81; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        for (int c = 1; c < 7; c++) applyStimulus();
        checkOutput("t5_fv_c7", 8'(frame_valid), 8'h0);
        applyStimulus();
        checkOutput("t5_fv_c8", 8'(frame_valid), 8'h1);
        checkOutput("t5_frame", frame, 8'h81);
        frame_ready = 1'b1;
        applyStimulus();
        frame_ready = 1'b0;

        // Start and mask changes while busy are ignored
        $display("[TB] ignored start and mask change");
        dIn = 8'hA5; ch_mask = 8'h0F; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        applyStimulus(); applyStimulus();
        ch_mask = 8'hFF; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        checkOutput("t6_ds_c4", 8'(ds), 8'h1);
        checkOutput("t6_busy_c4", 8'(busy), 8'h1);
        for (int c = 4; c < 13; c++) applyStimulus();
        checkOutput("t6_fv_c13", 8'(frame_valid), 8'h0);
        applyStimulus();
        checkOutput("t6_fv_c14", 8'(frame_valid), 8'h1);
        checkOutput("t6_frame", frame, 8'h05);
        checkOutput("t6_busy_c14", 8'(busy), 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
